// File: rtl/tlb_pkg.sv
// Shared types, constants and the ps-dependent VPPN compare for the TLB.
package tlb_pkg;

   localparam int unsigned TLBNUM = 16;
   localparam int unsigned IW     = $clog2(TLBNUM);

   localparam logic [5:0] PS_4K = 6'd12;
   localparam logic [5:0] PS_2M = 6'd21;

   localparam logic [4:0] INV_ALL0       = 5'd0;
   localparam logic [4:0] INV_ALL1       = 5'd1;
   localparam logic [4:0] INV_G          = 5'd2;
   localparam logic [4:0] INV_NG         = 5'd3;
   localparam logic [4:0] INV_NG_ASID    = 5'd4;
   localparam logic [4:0] INV_NG_ASID_VA = 5'd5;
   localparam logic [4:0] INV_G_ASID_VA  = 5'd6;

   typedef struct packed {
      logic [19:0] ppn;
      logic [1:0]  plv;
      logic [1:0]  mat;
      logic        d;
      logic        v;
   } tlb_page_t;

   typedef struct packed {
      logic        e;
      logic [18:0] vppn;
      logic [5:0]  ps;
      logic [9:0]  asid;
      logic        g;
      tlb_page_t   p0;
      tlb_page_t   p1;
   } tlb_entry_t;

   // VPPN compare only; e and asid are qualified by the caller.
   function automatic logic vppn_match(tlb_entry_t ent, logic [18:0] vppn);
      if (ent.ps == PS_4K) return ent.vppn == vppn;
      else if (ent.ps == PS_2M) return ent.vppn[18:9] == vppn[18:9];
      else return 1'b0;
   endfunction

endpackage

// File: rtl/tlb_search_port.sv
// One combinational lookup port: match vector, lowest-index priority, page select.
module tlb_search_port
   import tlb_pkg::*;
(
   input  tlb_entry_t [TLBNUM-1:0] entries,
   input  logic [18:0]             vppn,
   input  logic                    va_bit12,
   input  logic [9:0]              asid,
   output logic                    found,
   output logic [IW-1:0]           index,
   output logic [19:0]             ppn,
   output logic [5:0]              ps,
   output logic [1:0]              plv,
   output logic [1:0]              mat,
   output logic                    d,
   output logic                    v
);

   logic [TLBNUM-1:0] hit;
   tlb_entry_t        sel;
   tlb_page_t         pg;
   logic              odd;

   always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
         hit[i] = entries[i].e & (entries[i].g | (entries[i].asid == asid))
                  & vppn_match(entries[i], vppn);
      end
   end

   // Scan downward so the lowest matching index is the last assignment.
   always_comb begin
      found = 1'b0;
      index = '0;
      for (int i = TLBNUM - 1; i >= 0; i--) begin
         if (hit[i]) begin
            found = 1'b1;
            index = i[IW-1:0];
         end
      end
   end

   always_comb begin
      sel = entries[index];
      odd = (sel.ps == PS_4K) ? va_bit12 : vppn[8];
      pg  = odd ? sel.p1 : sel.p0;
      ppn = '0;
      ps  = '0;
      plv = '0;
      mat = '0;
      d   = 1'b0;
      v   = 1'b0;
      if (found) begin
         ppn = pg.ppn;
         ps  = sel.ps;
         plv = pg.plv;
         mat = pg.mat;
         d   = pg.d;
         v   = pg.v;
      end
   end

endmodule

// File: rtl/tlb.sv
// 16-entry fully-associative TLB: two lookup ports, read/write port, INVTLB.
module tlb
   import tlb_pkg::*;
(
   input  logic              clk,
   input  logic              reset,
   input  logic [18:0]       s0_vppn,
   input  logic              s0_va_bit12,
   input  logic [9:0]        s0_asid,
   output logic              s0_found,
   output logic [IW-1:0]     s0_index,
   output logic [19:0]       s0_ppn,
   output logic [5:0]        s0_ps,
   output logic [1:0]        s0_plv,
   output logic [1:0]        s0_mat,
   output logic              s0_d,
   output logic              s0_v,
   input  logic [18:0]       s1_vppn,
   input  logic              s1_va_bit12,
   input  logic [9:0]        s1_asid,
   output logic              s1_found,
   output logic [IW-1:0]     s1_index,
   output logic [19:0]       s1_ppn,
   output logic [5:0]        s1_ps,
   output logic [1:0]        s1_plv,
   output logic [1:0]        s1_mat,
   output logic              s1_d,
   output logic              s1_v,
   input  logic              invtlb_valid,
   input  logic [4:0]        invtlb_op,
   input  logic              we,
   input  logic [IW-1:0]     w_index,
   input  logic              w_e,
   input  logic              w_g,
   input  logic [18:0]       w_vppn,
   input  logic [5:0]        w_ps,
   input  logic [9:0]        w_asid,
   input  logic [19:0]       w_ppn0,
   input  logic [1:0]        w_plv0,
   input  logic [1:0]        w_mat0,
   input  logic              w_d0,
   input  logic              w_v0,
   input  logic [19:0]       w_ppn1,
   input  logic [1:0]        w_plv1,
   input  logic [1:0]        w_mat1,
   input  logic              w_d1,
   input  logic              w_v1,
   input  logic [IW-1:0]     r_index,
   output logic              r_e,
   output logic [18:0]       r_vppn,
   output logic [5:0]        r_ps,
   output logic [9:0]        r_asid,
   output logic              r_g,
   output logic [19:0]       r_ppn0,
   output logic [1:0]        r_plv0,
   output logic [1:0]        r_mat0,
   output logic              r_d0,
   output logic              r_v0,
   output logic [19:0]       r_ppn1,
   output logic [1:0]        r_plv1,
   output logic [1:0]        r_mat1,
   output logic              r_d1,
   output logic              r_v1
);

   tlb_entry_t [TLBNUM-1:0] entries_q, entries_d;
   tlb_entry_t              w_entry, r_entry;
   logic [TLBNUM-1:0]       inv_sel;

   tlb_search_port u_port0 (
      .entries (entries_q),
      .vppn    (s0_vppn),
      .va_bit12(s0_va_bit12),
      .asid    (s0_asid),
      .found   (s0_found),
      .index   (s0_index),
      .ppn     (s0_ppn),
      .ps      (s0_ps),
      .plv     (s0_plv),
      .mat     (s0_mat),
      .d       (s0_d),
      .v       (s0_v)
   );

   tlb_search_port u_port1 (
      .entries (entries_q),
      .vppn    (s1_vppn),
      .va_bit12(s1_va_bit12),
      .asid    (s1_asid),
      .found   (s1_found),
      .index   (s1_index),
      .ppn     (s1_ppn),
      .ps      (s1_ps),
      .plv     (s1_plv),
      .mat     (s1_mat),
      .d       (s1_d),
      .v       (s1_v)
   );

   always_comb begin
      w_entry = '{e: w_e, vppn: w_vppn, ps: w_ps, asid: w_asid, g: w_g,
                  p0: '{ppn: w_ppn0, plv: w_plv0, mat: w_mat0, d: w_d0, v: w_v0},
                  p1: '{ppn: w_ppn1, plv: w_plv1, mat: w_mat1, d: w_d1, v: w_v1}};
   end

   // INVTLB selection ignores e and va_bit12.
   always_comb begin
      for (int i = 0; i < TLBNUM; i++) begin
         case (invtlb_op)
            INV_ALL0, INV_ALL1: inv_sel[i] = 1'b1;
            INV_G:              inv_sel[i] = entries_q[i].g;
            INV_NG:             inv_sel[i] = ~entries_q[i].g;
            INV_NG_ASID:        inv_sel[i] = ~entries_q[i].g & (entries_q[i].asid == s1_asid);
            INV_NG_ASID_VA:     inv_sel[i] = ~entries_q[i].g & (entries_q[i].asid == s1_asid)
                                             & vppn_match(entries_q[i], s1_vppn);
            INV_G_ASID_VA:      inv_sel[i] = (entries_q[i].g | (entries_q[i].asid == s1_asid))
                                             & vppn_match(entries_q[i], s1_vppn);
            default:            inv_sel[i] = 1'b0;
         endcase
      end
   end

   // Invalidate first so a same-cycle write lands with its own e.
   always_comb begin
      entries_d = entries_q;
      if (invtlb_valid) begin
         for (int i = 0; i < TLBNUM; i++) begin
            if (inv_sel[i]) entries_d[i].e = 1'b0;
         end
      end
      if (we) entries_d[w_index] = w_entry;
   end

   always_ff @(posedge clk) begin
      if (reset) entries_q <= '0;
      else       entries_q <= entries_d;
   end

   always_comb begin
      r_entry = entries_q[r_index];
      r_e     = r_entry.e;
      r_vppn  = r_entry.vppn;
      r_ps    = r_entry.ps;
      r_asid  = r_entry.asid;
      r_g     = r_entry.g;
      r_ppn0  = r_entry.p0.ppn;
      r_plv0  = r_entry.p0.plv;
      r_mat0  = r_entry.p0.mat;
      r_d0    = r_entry.p0.d;
      r_v0    = r_entry.p0.v;
      r_ppn1  = r_entry.p1.ppn;
      r_plv1  = r_entry.p1.plv;
      r_mat1  = r_entry.p1.mat;
      r_d1    = r_entry.p1.d;
      r_v1    = r_entry.p1.v;
   end

endmodule
